// File: rtl/video_pattern_generator.sv
// Video timing and test-pattern source producing a DVI-style pixel stream.
// Optional macro PATTERN_SCROLL_EN: patterns scroll by one pixel (or line) per frame.
module video_pattern_generator #(
    parameter int H_ACTIVE    = 32,
    parameter int H_FRONT     = 4,
    parameter int H_SYNC      = 4,
    parameter int H_BLANK     = 16,
    parameter int V_ACTIVE    = 8,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 2,
    parameter int V_BLANK     = 4,
    parameter int COLOR_COUNT = 3
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic [1:0]  I_pattern_sel,
    output logic        O_rgb_vs,
    output logic        O_rgb_hs,
    output logic        O_rgb_de,
    output logic [7:0]  O_rgb_color [COLOR_COUNT],
    output logic        O_frame_start,
    output logic [15:0] O_frame_count,
    output logic        O_dbg_state
);

    // Push-only stream: O_rgb_de qualifies O_rgb_color on every cycle; there is
    // no ready, so the sink must accept each pixel in the cycle it is presented.

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [31:0] H_ACT_U  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_U  = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FRONT);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FRONT);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [31:0] BAR_W    = (H_ACTIVE / 8 < 1) ? 32'd1 : 32'(H_ACTIVE / 8);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            cnt_valid;
    logic [1:0]      sel_q;
    logic [15:0]     frame_cnt;
    logic            h_last;
    logic            v_last;
    logic            last_pix;

    logic            de_c;
    logic            hs_c;
    logic            vs_c;
    logic            fs_c;
    logic [31:0]     x_full;
    logic [31:0]     y_full;
    logic [31:0]     x_pat;
    logic [31:0]     y_pat;
    logic [31:0]     bar;
    logic [2:0]      bar_idx;
    logic [7:0]      r_c;
    logic [7:0]      g_c;
    logic [7:0]      b_c;
    logic [7:0]      color_c [COLOR_COUNT];

    assign h_last        = (h_cnt == H_LAST);
    assign v_last        = (v_cnt == V_LAST);
    assign last_pix      = (state == ST_RUN) && cnt_valid && h_last && v_last;
    assign O_frame_count = frame_cnt;
    assign O_dbg_state   = (state == ST_RUN);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A run only ends on the last pixel of a frame, so frames are never cut short.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (I_enable) state_next = ST_RUN;
            ST_RUN:  if (last_pix && !I_enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // cnt_valid marks the cycles where (h_cnt, v_cnt) is a real pixel position;
    // it lags entry into RUN by one cycle so the first frame starts at (0,0).
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            cnt_valid <= 1'b0;
        end else if (state != ST_RUN) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            cnt_valid <= 1'b0;
        end else begin
            cnt_valid <= (state_next == ST_RUN);
            if (cnt_valid) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_cnt <= '0;
            sel_q     <= '0;
        end else begin
            if (last_pix) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((state == ST_IDLE && I_enable) || (last_pix && I_enable)) begin
                sel_q <= I_pattern_sel;
            end
        end
    end

    always_comb begin
        x_full = 32'(h_cnt);
        y_full = 32'(v_cnt);
`ifdef PATTERN_SCROLL_EN
        x_pat  = (x_full + 32'(frame_cnt)) % H_ACT_U;
        y_pat  = (y_full + 32'(frame_cnt)) % V_ACT_U;
`else
        x_pat  = x_full;
        y_pat  = y_full;
`endif
        de_c = cnt_valid && (x_full < H_ACT_U) && (y_full < V_ACT_U);
        hs_c = cnt_valid && (x_full >= HS_START) && (x_full < HS_END);
        vs_c = cnt_valid && (y_full >= VS_START) && (y_full < VS_END);
        fs_c = cnt_valid && (h_cnt == '0) && (v_cnt == '0);

        // The last bar absorbs the remainder when H_ACTIVE is not a multiple of 8.
        bar = x_pat / BAR_W;
        if (bar > 32'd7) begin
            bar = 32'd7;
        end
        bar_idx = bar[2:0];

        r_c = 8'h00;
        g_c = 8'h00;
        b_c = 8'h00;
        case (sel_q)
            2'd0: begin
                r_c = x_pat[7:0];
                g_c = x_pat[7:0];
                b_c = x_pat[7:0];
            end
            2'd1: begin
                r_c = y_pat[7:0];
                g_c = y_pat[7:0];
                b_c = y_pat[7:0];
            end
            2'd2: begin
                r_c = {8{bar_idx[2]}};
                g_c = {8{bar_idx[1]}};
                b_c = {8{bar_idx[0]}};
            end
            default: begin
                r_c = x_pat[7:0];
                g_c = y_full[7:0];
                b_c = frame_cnt[7:0];
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < COLOR_COUNT; i++) begin
            color_c[i] = 8'h00;
            if (de_c) begin
                if (i == 1) begin
                    color_c[i] = g_c;
                end else if (i == 2) begin
                    color_c[i] = b_c;
                end else begin
                    color_c[i] = r_c;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rgb_de      <= 1'b0;
            O_rgb_hs      <= 1'b0;
            O_rgb_vs      <= 1'b0;
            O_frame_start <= 1'b0;
            for (int i = 0; i < COLOR_COUNT; i++) begin
                O_rgb_color[i] <= 8'h00;
            end
        end else begin
            O_rgb_de      <= de_c;
            O_rgb_hs      <= hs_c;
            O_rgb_vs      <= vs_c;
            O_frame_start <= fs_c;
            for (int i = 0; i < COLOR_COUNT; i++) begin
                O_rgb_color[i] <= color_c[i];
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_generator.sv
// Bench for video_pattern_generator: directed sequence with random selects and
// run lengths, checked every cycle against a frame/pixel arithmetic model.
module tb_video_pattern_generator;

  localparam int H_ACT = 32;
  localparam int H_TOT = 48;
  localparam int V_ACT = 8;
  localparam int V_TOT = 12;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        vs;
  logic        hs;
  logic        de;
  logic        fs;
  logic        st;
  logic [7:0]  color [3];
  logic [15:0] fc;

  video_pattern_generator dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_enable      (en),
    .I_pattern_sel (sel),
    .O_rgb_vs      (vs),
    .O_rgb_hs      (hs),
    .O_rgb_de      (de),
    .O_rgb_color   (color),
    .O_frame_start (fs),
    .O_frame_count (fc),
    .O_dbg_state   (st)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int de_seen = 0;

  // reference model: run flag, edges since start, latched select and counts
  bit          m_run = 1'b0;
  int          m_k = 0;
  logic [1:0]  m_sel = 2'd0;
  logic [15:0] m_fc = 16'd0;
  logic [15:0] m_ffc = 16'd0;
  logic [44:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    m_fc  = 16'd0;
    m_ffc = 16'd0;
    m_sel = 2'd0;
  endtask

  // Outputs for pixel p appear two edges after the enable-sampling edge plus p.
  task automatic model_edge();
    int p;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_k   = 0;
        m_sel = sel;
        m_ffc = m_fc;
      end
    end else begin
      m_k++;
      p = m_k - 2;
      if (p >= 0 && (p % FRAME) == FRAME - 1) begin
        m_fc = m_fc + 16'd1;
        if (!en) begin
          m_run = 1'b0;
        end else begin
          m_sel = sel;
          m_ffc = m_fc;
        end
      end
    end
  endtask

  function automatic logic [44:0] expect_out();
    logic [3:0] ctl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int p, pos, x, y, xs, ys, bi;
    ctl = 4'd0;
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    if (m_run && m_k >= 2) begin
      p   = m_k - 2;
      pos = p % FRAME;
      x   = pos % H_TOT;
      y   = pos / H_TOT;
      ctl = {(x < H_ACT && y < V_ACT), (x >= 36 && x < 40), (y >= 9 && y < 11), (pos == 0)};
      xs  = x;
      ys  = y;
`ifdef PATTERN_SCROLL_EN
      xs  = (x + int'(m_ffc)) % H_ACT;
      ys  = (y + int'(m_ffc)) % V_ACT;
`endif
      if (ctl[3]) begin
        case (m_sel)
          2'd0: begin r = 8'(xs); g = 8'(xs); b = 8'(xs); end
          2'd1: begin r = 8'(ys); g = 8'(ys); b = 8'(ys); end
          2'd2: begin
            bi = xs / (H_ACT / 8);
            if (bi > 7) bi = 7;
            r = ((bi & 4) != 0) ? 8'hFF : 8'h00;
            g = ((bi & 2) != 0) ? 8'hFF : 8'h00;
            b = ((bi & 1) != 0) ? 8'hFF : 8'h00;
          end
          default: begin r = 8'(xs); g = 8'(y); b = m_ffc[7:0]; end
        endcase
      end
    end
    return {m_run, ctl, r, g, b, m_fc};
  endfunction

  // scoreboard
  task automatic compare_out();
    logic [44:0] e;
    e = exp_q.pop_front();
    check("state", 32'(st), 32'(e[44]));
    check("de_hs_vs_fs", 32'({de, hs, vs, fs}), 32'(e[43:40]));
    check("rgb", 32'({color[0], color[1], color[2]}), 32'(e[39:16]));
    check("frame_count", 32'(fc), 32'(e[15:0]));
    if (de) de_seen++;
  endtask

  // driver
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      exp_q.push_back(expect_out());
      @(negedge clk);
      compare_out();
    end
  endtask

  initial begin
    en  = 1'b1;
    sel = 2'd0;
    #1 rst_n = 1'b0;
    run_cycles(3);
    rst_n   = 1'b1;
    de_seen = 0;

    // gradient frame, then sel change mid-frame takes effect on the next frame
    run_cycles(300);
    sel = 2'd3;
    run_cycles(576);
    sel = 2'd2;
    run_cycles(576);
    sel = 2'd1;
    run_cycles(576);
    en = 1'b0;
    run_cycles(700);
    check("de_total_4_frames", 32'(de_seen), 32'(4 * 256));
    check("frames_after_stop", 32'(fc), 32'd4);

    // random selects, run lengths and stop points
    for (int r = 0; r < 3; r++) begin
      sel = 2'($urandom_range(0, 3));
      en  = 1'b1;
      for (int c = 0; c < 4; c++) begin
        run_cycles($urandom_range(50, 500));
        sel = 2'($urandom_range(0, 3));
      end
      en = 1'b0;
      run_cycles(1200);
      run_cycles($urandom_range(1, 20));
    end

    // asynchronous reset in the middle of an active line
    sel = 2'd0;
    en  = 1'b1;
    run_cycles(20);
    @(posedge clk);
    model_edge();
    exp_q.push_back(expect_out());
    #1 compare_out();
    #1 rst_n = 1'b0;
    model_reset();
    #1 exp_q.push_back(expect_out());
    compare_out();
    run_cycles(3);
    rst_n = 1'b1;
    run_cycles(300);
    en = 1'b0;
    run_cycles(700);

    // frame counter wrap from FFFF
    force dut.frame_cnt = 16'hFFFF;
    #1 release dut.frame_cnt;
    m_fc = 16'hFFFF;
    run_cycles(2);
    sel = 2'd3;
    en  = 1'b1;
    run_cycles(300);
    en = 1'b0;
    run_cycles(700);
    check("frame_count_wrap", 32'(fc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
